// File: rtl/rep_string_sequencer_if.sv
// Stage-0 / stage-1 / writeback signal bundle of the REP string sequencer.
// Handshake: a beat moves when out_valid && out_ready on a rising clk edge; in_ready marks the instruction consumed.
interface rep_string_sequencer_if #(
  parameter int CNTW   = 32,
  parameter int IADDRW = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_rep;
  logic              in_cmp;
  logic              in_addr32;
  logic [IADDRW-1:0] in_pc;
  logic [CNTW-1:0]   ecx_in;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [IADDRW-1:0] out_pc;
  logic              wb_valid;
  logic [2:0]        wb_reg;
  logic [CNTW-1:0]   wb_data;
  logic [2:0]        wb_size;
  logic              zf_valid;
  logic              zf;
  logic              pending_int;
  logic              hold_int;
  logic              int_break;
  logic              busy;
  logic [1:0]        dbg_state;

  modport master (
    output flush, in_valid, in_rep, in_cmp, in_addr32, in_pc, ecx_in,
           out_ready, zf_valid, zf, pending_int,
    input  in_ready, out_valid, out_last, out_pc, wb_valid, wb_reg, wb_data,
           wb_size, hold_int, int_break, busy, dbg_state
  );

  modport slave (
    input  flush, in_valid, in_rep, in_cmp, in_addr32, in_pc, ecx_in,
           out_ready, zf_valid, zf, pending_int,
    output in_ready, out_valid, out_last, out_pc, wb_valid, wb_reg, wb_data,
           wb_size, hold_int, int_break, busy, dbg_state
  );
endinterface

// File: rtl/rep_string_sequencer.sv
// REP-prefix iteration engine: one beat per string iteration with count writeback, interrupts at boundaries.
// Define REP_SEQ_FLAG_TERM_EN to enable REPE/REPNE termination on ZF (WAIT_FLAG state).
module rep_string_sequencer #(
  parameter int CNTW   = 32,
  parameter int IADDRW = 32
) (
  input logic                   clk,
  input logic                   reset,
  rep_string_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_FLAG = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LO_MASK = CNTW'(16'hFFFF);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            addr32;
  logic            bnd;
  logic [2:0]      wb_size_q;

  logic [CNTW-1:0] load_cnt;
  logic [CNTW-1:0] dec_cnt;
  logic            rep_req;
  logic            load;
  logic            seq_last;
  logic            int_take;
  logic            seq_valid;
  logic            accept;
  logic            cmp_en;
  logic            flag_seen;
  logic            flag_stop;
  logic            wb_fire;

  assign rep_req   = (bus.in_rep != 2'b00);
  assign load_cnt  = bus.in_addr32 ? bus.ecx_in : (bus.ecx_in & LO_MASK);
  assign load      = (state == IDLE) && bus.in_valid && rep_req && !bus.flush;
  assign seq_last  = (cnt == CNTW'(1));
  assign dec_cnt   = cnt - CNTW'(1);
  // The cycle after a non-final beat is an iteration boundary; an interrupt there abandons the sequence.
  assign int_take  = (state == ISSUE) && bnd && bus.pending_int;
  assign seq_valid = (state == ISSUE) && !int_take;
  assign accept    = seq_valid && bus.out_ready;

`ifdef REP_SEQ_FLAG_TERM_EN
  logic rep_ne;
  logic cmp;
  assign cmp_en    = cmp;
  assign flag_seen = (state == WAIT_FLAG) && bus.zf_valid;
  assign flag_stop = flag_seen && (rep_ne ? bus.zf : !bus.zf);
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{bus.zf, bus.zf_valid, bus.in_cmp};
  assign cmp_en    = 1'b0;
  assign flag_seen = 1'b0;
  assign flag_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr32    <= 1'b0;
      bnd       <= 1'b0;
      wb_size_q <= 3'd0;
`ifdef REP_SEQ_FLAG_TERM_EN
      rep_ne    <= 1'b0;
      cmp       <= 1'b0;
`endif
    end else begin
      bnd <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              cnt       <= load_cnt;
              addr32    <= bus.in_addr32;
              wb_size_q <= bus.in_addr32 ? 3'd3 : 3'd2;
`ifdef REP_SEQ_FLAG_TERM_EN
              rep_ne    <= (bus.in_rep == 2'b10);
              cmp       <= bus.in_cmp;
`endif
              if (load_cnt != '0) state <= ISSUE;
            end
          end
          ISSUE: begin
            if (int_take) begin
              state <= IDLE;
            end else if (accept) begin
              cnt <= dec_cnt;
              if (seq_last)    state <= IDLE;
              else if (cmp_en) state <= WAIT_FLAG;
              else             bnd   <= 1'b1;
            end
          end
          WAIT_FLAG: begin
            if (flag_stop) begin
              state <= IDLE;
            end else if (flag_seen) begin
              state <= ISSUE;
              bnd   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.int_break = 1'b0;
    bus.hold_int  = 1'b0;
    wb_fire       = 1'b0;
    case (state)
      IDLE: begin
        if (!rep_req) begin
          bus.out_valid = bus.in_valid;
          bus.out_last  = bus.in_valid;
          bus.in_ready  = bus.out_ready;
        end else begin
          bus.in_ready  = bus.in_valid && (load_cnt == '0);
        end
      end
      ISSUE: begin
        bus.out_valid = seq_valid;
        bus.out_last  = seq_valid && seq_last;
        bus.in_ready  = accept && seq_last;
        bus.int_break = int_take;
        bus.hold_int  = bus.pending_int && seq_valid;
        wb_fire       = accept;
      end
      WAIT_FLAG: begin
        bus.in_ready  = flag_stop;
        bus.hold_int  = bus.pending_int;
      end
      default: ;
    endcase
    if (bus.flush) begin
      bus.in_ready  = 1'b0;
      bus.int_break = 1'b0;
      wb_fire       = 1'b0;
    end
  end

  // In CX mode the upper half of ECX is carried through untouched.
  assign bus.wb_valid  = wb_fire;
  assign bus.wb_data   = !wb_fire ? '0 :
                         addr32   ? dec_cnt :
                                    ((bus.ecx_in & ~LO_MASK) | (dec_cnt & LO_MASK));
  assign bus.wb_reg    = 3'b001;
  assign bus.wb_size   = wb_size_q;
  assign bus.out_pc    = bus.in_pc;
  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_rep_string_sequencer.sv
// Randomized bench for rep_string_sequencer: per-instruction reference model feeding a writeback queue,
// plus cycle checks of the beat/handshake outputs. Follows REP_SEQ_FLAG_TERM_EN if defined.
module tb_rep_string_sequencer;
  localparam int CNTW   = 32;
  localparam int IADDRW = 32;
`ifdef REP_SEQ_FLAG_TERM_EN
  localparam bit FLAG_MODE = 1'b1;
`else
  localparam bit FLAG_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rep_string_sequencer_if #(.CNTW(CNTW), .IADDRW(IADDRW)) bus ();
  rep_string_sequencer #(.CNTW(CNTW), .IADDRW(IADDRW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [CNTW-1:0] exp_q[$];
  logic            cur_a32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_rep = 2'b00; bus.in_cmp = 1'b0;
    bus.in_addr32 = 1'b0; bus.in_pc = '0; bus.ecx_in = '0; bus.out_ready = 1'b0;
    bus.zf_valid = 1'b0; bus.zf = 1'b0; bus.pending_int = 1'b0;
  endtask

  // Scoreboard: every writeback strobe consumes one expected count value.
  task automatic sample_wb();
    logic [CNTW-1:0] want;
    if (bus.wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_extra_strobe", bus.wb_valid, 1'b0);
      end else begin
        want = exp_q.pop_front();
        check("wb_data", bus.wb_data, want);
        check("wb_size", bus.wb_size, cur_a32 ? 3'd3 : 3'd2);
        check("wb_reg", bus.wb_reg, 3'b001);
      end
    end
  endtask

  task automatic run_pass(input bit v, input bit r);
    logic [IADDRW-1:0] pc;
    pc = IADDRW'($urandom);
    @(posedge clk); #1;
    idle_inputs();
    bus.in_valid = v; bus.out_ready = r; bus.in_pc = pc;
    bus.ecx_in = CNTW'($urandom); bus.in_cmp = 1'($urandom_range(0, 1));
    bus.in_addr32 = 1'($urandom_range(0, 1)); bus.pending_int = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("pt_out_valid", bus.out_valid, v);
    check("pt_in_ready", bus.in_ready, r);
    check("pt_out_last", bus.out_last, v);
    check("pt_out_pc", bus.out_pc, pc);
    check("pt_wb_valid", bus.wb_valid, 1'b0);
    check("pt_busy", bus.busy, 1'b0);
    check("pt_int_break", bus.int_break, 1'b0);
  endtask

  task automatic run_seq(input logic [1:0] rep, input logic cmp, input logic a32,
                         input logic [CNTW-1:0] ecx, input logic [15:0] zf_bits,
                         input int int_beat, input int flush_beat, input bit full_rdy);
    int n, m, done, budget, wait_cnt, phase;
    bit flag_on, stop, ended, boundary, int_on, last;
    logic [IADDRW-1:0] pc;
    n = a32 ? int'(ecx) : int'(ecx[15:0]);
    flag_on = FLAG_MODE && cmp;
    // Reference: how many beats write back before the instruction ends.
    m = n;
    for (int k = 1; k < n; k++) begin
      if (flag_on && ((rep == 2'b10) ? zf_bits[k-1] : !zf_bits[k-1])) begin m = k; break; end
      if (int_beat == k) begin m = k; break; end
    end
    if (flush_beat != 0 && flush_beat <= m) m = flush_beat - 1;
    exp_q.delete();
    for (int k = 1; k <= m; k++)
      exp_q.push_back(a32 ? ecx - CNTW'(k) : {ecx[CNTW-1:16], 16'(n - k)});
    cur_a32 = a32;
    pc = IADDRW'($urandom);

    @(posedge clk); #1;
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_rep = rep; bus.in_cmp = cmp; bus.in_addr32 = a32;
    bus.ecx_in = ecx; bus.in_pc = pc;
    bus.out_ready = full_rdy ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    sample_wb();
    check("load_out_valid", bus.out_valid, 1'b0);
    check("load_in_ready", bus.in_ready, n == 0);
    check("load_busy", bus.busy, 1'b0);

    done = 0; phase = 0; boundary = 0; wait_cnt = 0; budget = 300;
    int_on = (int_beat == 1); ended = (n == 0);
    while (!ended && budget > 0) begin
      budget--;
      @(posedge clk); #1;
      bus.out_ready = full_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.flush = 1'b0;
      bus.zf = 1'($urandom_range(0, 1));
      bus.zf_valid = (phase == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (phase == 1) begin
        if (wait_cnt == 0) begin bus.zf_valid = 1'b1; bus.zf = zf_bits[done-1]; end
        else wait_cnt--;
      end
      if (int_beat != 0 && boundary && done == int_beat) int_on = 1'b1;
      bus.pending_int = int_on;
      if (phase == 0 && flush_beat != 0 && done == flush_beat - 1) bus.flush = 1'b1;
      @(negedge clk);
      sample_wb();
      if (bus.flush) begin
        check("flush_wb_valid", bus.wb_valid, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b0);
        check("flush_int_break", bus.int_break, 1'b0);
        ended = 1'b1;
      end else if (phase == 0 && boundary && int_on) begin
        check("brk_int_break", bus.int_break, 1'b1);
        check("brk_out_valid", bus.out_valid, 1'b0);
        check("brk_in_ready", bus.in_ready, 1'b0);
        check("brk_hold_int", bus.hold_int, 1'b0);
        check("brk_wb_valid", bus.wb_valid, 1'b0);
        ended = 1'b1;
      end else if (phase == 0) begin
        last = (done + 1 == n);
        check("beat_out_valid", bus.out_valid, 1'b1);
        check("beat_out_last", bus.out_last, last);
        check("beat_out_pc", bus.out_pc, pc);
        check("beat_hold_int", bus.hold_int, int_on);
        check("beat_int_break", bus.int_break, 1'b0);
        check("beat_busy", bus.busy, 1'b1);
        boundary = 1'b0;
        if (bus.out_ready) begin
          check("acc_wb_valid", bus.wb_valid, 1'b1);
          check("acc_in_ready", bus.in_ready, last);
          done++;
          if (last) ended = 1'b1;
          else if (flag_on) begin phase = 1; wait_cnt = $urandom_range(0, 2); end
          else boundary = 1'b1;
        end else begin
          check("stall_wb_valid", bus.wb_valid, 1'b0);
          check("stall_in_ready", bus.in_ready, 1'b0);
        end
      end else begin
        check("wait_out_valid", bus.out_valid, 1'b0);
        check("wait_hold_int", bus.hold_int, int_on);
        check("wait_wb_valid", bus.wb_valid, 1'b0);
        if (bus.zf_valid) begin
          stop = (rep == 2'b10) ? bus.zf : !bus.zf;
          check("wait_in_ready", bus.in_ready, stop);
          if (stop) ended = 1'b1;
          else begin phase = 0; boundary = 1'b1; end
        end else begin
          check("wait_in_ready", bus.in_ready, 1'b0);
        end
      end
    end
    if (!ended) check("seq_timeout", 1'b1, 1'b0);
    check("wb_missing", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    sample_wb();
    check("end_busy", bus.busy, 1'b0);
    check("end_out_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [1:0]      rep;
    logic            cmp, a32;
    logic [CNTW-1:0] ecx;
    int              n, ib, fb;

    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_wb_data", bus.wb_data, '0);
    check("rst_wb_reg", bus.wb_reg, 3'b001);
    check("rst_wb_size", bus.wb_size, 3'd0);
    check("rst_hold_int", bus.hold_int, 1'b0);
    check("rst_int_break", bus.int_break, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b1;

    run_pass(1'b1, 1'b1);
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b1);
    run_seq(2'b01, 1'b0, 1'b1, 32'd3, 16'h0, 0, 0, 1'b1);
    run_seq(2'b01, 1'b0, 1'b0, 32'hABCD_0002, 16'h0, 0, 0, 1'b1);
    run_seq(2'b01, 1'b1, 1'b1, 32'd5, 16'b011, 0, 0, 1'b1);
    run_seq(2'b10, 1'b1, 1'b1, 32'd4, 16'b100, 0, 0, 1'b0);
    run_seq(2'b01, 1'b0, 1'b1, 32'd4, 16'h0, 1, 0, 1'b0);
    run_seq(2'b11, 1'b0, 1'b1, 32'd0, 16'h0, 0, 0, 1'b1);
    run_seq(2'b01, 1'b0, 1'b0, 32'h1234_0000, 16'h0, 0, 0, 1'b1);
    run_seq(2'b01, 1'b0, 1'b1, 32'd4, 16'h0, 0, 2, 1'b1);

    // Asynchronous reset in the middle of a sequence.
    @(posedge clk); #1;
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_rep = 2'b01; bus.in_addr32 = 1'b1;
    bus.ecx_in = 32'd6; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_wb_valid", bus.wb_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_wb_size", bus.wb_size, 3'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rep = 2'($urandom_range(1, 3));
      cmp = 1'($urandom_range(0, 1));
      a32 = 1'($urandom_range(0, 1));
      n   = $urandom_range(0, 6);
      ecx = a32 ? CNTW'(n) : {16'($urandom), 16'(n)};
      ib = 0; fb = 0;
      case ($urandom_range(0, 3))
        1: if (n > 1) ib = $urandom_range(1, n - 1);
        2: if (n > 0) fb = $urandom_range(1, n);
        default: ;
      endcase
      run_seq(rep, cmp, a32, ecx, 16'($urandom), ib, fb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
